// File: rtl/key_conditioner_if.sv
// Key bus between raw pushbuttons and the conditioned level/action outputs.
interface key_conditioner_if;
  logic [3:0] iKEY;     // raw pushbuttons, active-low
  logic [3:0] oLevel;   // debounced held state, active-high
  logic [3:0] oAction;  // one-cycle press / auto-repeat pulses

  modport master (output iKEY, input oLevel, oAction);
  modport slave  (input iKEY, output oLevel, oAction);
endinterface

// File: rtl/key_conditioner.sv
// Four-key synchronizer, debouncer and press-pulse generator.
// Define KEY_CONDITIONER_REPEAT_EN to add per-key auto-repeat.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 2500000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b0110
) (
  input  logic          iCLK_50M,
  input  logic          iRST_N,
  key_conditioner_if.slave kbus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    level_q, level_d;
  logic [3:0]    action_q, action_d;
  logic [3:0]    rise, fall;
  logic [DW-1:0] dcnt_q [4];
  logic [DW-1:0] dcnt_d [4];

  // Counter runs only while the synchronized key disagrees with the accepted level.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      level_d[i] = level_q[i];
      dcnt_d[i]  = '0;
      rise[i]    = 1'b0;
      fall[i]    = 1'b0;
      if (~sync2_q[i] != level_q[i]) begin
        if (dcnt_q[i] + DW'(1) == DW'(DEBOUNCE_CYCLES)) begin
          level_d[i] = ~level_q[i];
          rise[i]    = ~level_q[i];
          fall[i]    = level_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]    st_q   [4];
  logic [1:0]    st_d   [4];
  logic [RW-1:0] rcnt_q [4];
  logic [RW-1:0] rcnt_d [4];
  logic [3:0]    rpt;

  // Release is checked first so a repeat due on the release cycle is dropped.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];
      rpt[i]    = 1'b0;
      if (fall[i]) begin
        st_d[i]   = ST_IDLE;
        rcnt_d[i] = '0;
      end else if (rise[i]) begin
        st_d[i]   = ST_WAIT;
        rcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_WAIT: begin
            if (REPEAT_MASK[i]) begin
              if (rcnt_q[i] + RW'(1) == RW'(REPEAT_DELAY)) begin
                st_d[i]   = ST_REPEAT;
                rcnt_d[i] = '0;
                rpt[i]    = 1'b1;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (rcnt_q[i] + RW'(1) == RW'(REPEAT_RATE)) begin
              rcnt_d[i] = '0;
              rpt[i]    = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK_50M or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]   <= ST_IDLE;
        rcnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]   <= st_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  assign action_d = rise | rpt;
`else
  assign action_d = rise;
`endif

  always_ff @(posedge iCLK_50M or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      level_q  <= '0;
      action_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= kbus.iKEY;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      action_q <= action_d;
      for (int unsigned i = 0; i < 4; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign kbus.oLevel  = level_q;
  assign kbus.oAction = action_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_key_conditioner;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  key_conditioner_if kbus ();

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3),
    .REPEAT_MASK     (4'b0110)
  ) dut (
    .iCLK_50M (clk),
    .iRST_N   (rst_n),
    .kbus     (kbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [3:0] exp_lvl;
    logic [3:0] exp_act;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    kbus.iKEY = 4'hF;

    // Reset state
    repeat (3) tick();
    check_eq("rst_level", 32'(kbus.oLevel), 32'h0);
    check_eq("rst_action", 32'(kbus.oAction), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_level", 32'(kbus.oLevel), 32'h0);

    // Key 0: level rises on the 6th edge after the press, one pulse, masked for repeat
    kbus.iKEY[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("k0_level", 32'(kbus.oLevel), (k == 6) ? 32'h1 : 32'h0);
      check_eq("k0_action", 32'(kbus.oAction), (k == 6) ? 32'h1 : 32'h0);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pulses += int'(kbus.oAction[0]);
    end
    check_eq("k0_no_repeat", 32'(pulses), 32'h0);
    check_eq("k0_held", 32'(kbus.oLevel), 32'h1);
    kbus.iKEY[0] = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      pulses += int'(kbus.oAction[0]);
      check_eq("k0_release_level", 32'(kbus.oLevel), (k < 6) ? 32'h1 : 32'h0);
    end
    check_eq("k0_release_pulse", 32'(pulses), 32'h0);

    // Key 1: 3-cycle glitch is rejected
    kbus.iKEY[1] = 1'b0;
    repeat (3) tick();
    kbus.iKEY[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      pulses += int'(kbus.oLevel[1]) + int'(kbus.oAction[1]);
    end
    check_eq("k1_glitch", 32'(pulses), 32'h0);

    // Key 2: press, repeats at +10,+13,..., release after +31 so the fall lands on a repeat slot
    kbus.iKEY[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("k2_press", 32'(kbus.oAction), (k == 6) ? 32'h4 : 32'h0);
    end
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_lvl = (k < 37) ? 4'b0100 : 4'b0000;
`ifdef KEY_CONDITIONER_REPEAT_EN
      exp_act = (k < 37 && k >= 10 && ((k - 10) % 3) == 0) ? 4'b0100 : 4'b0000;
`else
      exp_act = 4'b0000;
`endif
      check_eq("k2_level", 32'(kbus.oLevel), 32'(exp_lvl));
      check_eq("k2_action", 32'(kbus.oAction), 32'(exp_act));
      if (k == 31) kbus.iKEY[2] = 1'b1;
    end

    // Keys 1 and 2 together
    kbus.iKEY = 4'b1001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("k12_action", 32'(kbus.oAction), (k == 6) ? 32'h6 : 32'h0);
    end
    check_eq("k12_level", 32'(kbus.oLevel), 32'h6);
    kbus.iKEY = 4'hF;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses += int'(kbus.oAction[1]) + int'(kbus.oAction[2]);
    end
    check_eq("k12_release_pulse", 32'(pulses), 32'h0);
    check_eq("k12_release_level", 32'(kbus.oLevel), 32'h0);

    // Reset mid-repeat with key 2 still held
    kbus.iKEY[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("k2r_press", 32'(kbus.oAction), (k == 6) ? 32'h4 : 32'h0);
    end
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_level", 32'(kbus.oLevel), 32'h0);
    check_eq("midrst_action", 32'(kbus.oAction), 32'h0);
    repeat (2) tick();
    check_eq("inrst_level", 32'(kbus.oLevel), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("postrst_action", 32'(kbus.oAction), (k == 6) ? 32'h4 : 32'h0);
      check_eq("postrst_level", 32'(kbus.oLevel), (k == 6) ? 32'h4 : 32'h0);
    end
    kbus.iKEY[2] = 1'b1;
    repeat (8) tick();
    check_eq("final_level", 32'(kbus.oLevel), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples (20 ms at 50 MHz) required to accept a level change.
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, meaning cycles from press pulse to first repeat pulse (250 ms).
REQ-003 SHALL have parameter REPEAT_RATE, default 2500000, meaning cycles between subsequent repeat pulses (50 ms).
REQ-004 SHALL have parameter REPEAT_MASK, default 4'b0110, meaning per-key auto-repeat enable (bit i = key i).
REQ-005 SHALL have port iCLK_50M input 1: the single clock; all state on its rising edge.
REQ-006 SHALL have port iRST_N input 1: reset, asynchronous, active-low.
REQ-007 SHALL have port iKEY input 4: raw pushbuttons, active-low (0 = pressed), asynchronous to iCLK_50M.
REQ-008 SHALL have port oLevel output 4: debounced key state, active-high (1 = held).
REQ-009 SHALL have port oAction output 4: one-cycle pulse per accepted press or auto-repeat event, consumed by the tetris game block.

Function
REQ-010 SHALL pass each iKEY bit through a two-flop synchronizer before any other logic.
REQ-011 SHALL keep an independent debounce counter per key; counter clears whenever synchronized level equals oLevel (inverted polarity), else increments.
REQ-012 SHALL toggle oLevel[i] on the cycle the counter for key i reaches DEBOUNCE_CYCLES, clearing the counter; latency from iKEY edge to oLevel change = DEBOUNCE_CYCLES+2 cycles.
REQ-013 SHALL ignore any disagreement shorter than DEBOUNCE_CYCLES consecutive samples (glitch/bounce rejected, counter restarts).
REQ-014 SHALL assert oAction[i] for exactly one cycle, registered, on the same cycle oLevel[i] rises; no pulse on release.
REQ-015 SHALL run a per-key FSM: IDLE -> (oLevel rise) WAIT -> (REPEAT_DELAY cycles elapsed) REPEAT -> (each REPEAT_RATE cycles) REPEAT; any state -> IDLE on oLevel fall.
REQ-016 SHALL pulse oAction[i] for one cycle at WAIT->REPEAT and at each REPEAT_RATE expiry, only when REPEAT_MASK[i]=1; masked keys stay in IDLE/WAIT without repeat pulses.
REQ-017 SHALL clear the repeat counter on release; release on the same cycle a repeat would fire suppresses that pulse.
REQ-018 SHALL treat the four keys fully independently; simultaneous events on multiple keys produce simultaneous oAction bits.
REQ-019 SHALL size counters as $clog2 of the largest parameter +1, with no wrap-around reachable.

Reset
REQ-020 SHALL, while iRST_N=0, force oLevel=4'b0000, oAction=4'b0000, all counters 0, all FSMs IDLE, synchronizer flops 1 (released).
REQ-021 SHALL produce no oAction pulse after reset release for a key held through reset until DEBOUNCE_CYCLES+2 cycles have elapsed (then one press pulse).
REQ-022 SHALL abort any debounce or repeat in progress when reset asserts mid-operation.

Configuration
REQ-023 SHALL, with macro KEY_CONDITIONER_REPEAT_EN defined, implement REQ-015..REQ-017 auto-repeat.
REQ-024 SHALL, without KEY_CONDITIONER_REPEAT_EN, omit repeat FSMs and counters; oAction pulses only on press (REQ-014), REPEAT_DELAY/REPEAT_RATE/REPEAT_MASK unused.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=4'b0110)
REQ-025 SHALL cover: iKEY[0] 1->0 held 20 cycles -> oLevel[0] rises 6 cycles after edge, single oAction[0] pulse, no repeats (masked).
REQ-026 SHALL cover: iKEY[1] low for 3 cycles then high -> oLevel[1] and oAction[1] stay 0.
REQ-027 SHALL cover: iKEY[2] held 30 cycles after press -> oAction[2] pulses at press, press+10, press+13, press+16, ...; release -> oLevel[2] falls 6 cycles later, no further pulses.
REQ-028 SHALL cover: iKEY[1] and iKEY[2] pressed same cycle -> oAction = 4'b0110 on one cycle.
REQ-029 SHALL cover: iRST_N pulsed low during REPEAT on key 2 -> outputs 0 immediately; key still held -> one press pulse 6 cycles after iRST_N rises.
REQ-030 SHALL cover: build without KEY_CONDITIONER_REPEAT_EN, key 2 held 30 cycles -> exactly one oAction[2] pulse.
